// File: rtl/flex_counter_nd.sv
// ============================================================================
// Module  : flex_counter_nd
// Brief   : N-stage cascaded counter / address generator with per-stage bounds,
//           step and mode (up-wrap, down-wrap, bounce, hold), optional one-shot.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flex_counter_nd #(
  parameter int NUM_STAGES = 2,
  parameter int SIZE       = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       clear,
  input  logic                       count_enable,
  input  logic                       oneshot,
  input  logic [NUM_STAGES*SIZE-1:0] lo_val,
  input  logic [NUM_STAGES*SIZE-1:0] hi_val,
  input  logic [NUM_STAGES*SIZE-1:0] step_val,
  input  logic [NUM_STAGES*2-1:0]    mode,
  output logic [NUM_STAGES*SIZE-1:0] count_out,
  output logic [NUM_STAGES-1:0]      wrap_flag,
  output logic                       done
);

  localparam logic [1:0] c_MODE_UP     = 2'b00;
  localparam logic [1:0] c_MODE_DOWN   = 2'b01;
  localparam logic [1:0] c_MODE_BOUNCE = 2'b10;

  // The start value depends on live bounds, so instead of an async load of
  // data-dependent values, r_at_start selects the start values until the next edge.
  logic                       r_at_start;
  logic [NUM_STAGES*SIZE-1:0] r_count;
  logic [NUM_STAGES-1:0]      r_dir_down;
  logic [NUM_STAGES-1:0]      r_wrap;
  logic                       r_done;

  logic [NUM_STAGES*SIZE-1:0] w_cur;
  logic [NUM_STAGES*SIZE-1:0] w_count_d;
  logic [NUM_STAGES-1:0]      w_term;
  logic [NUM_STAGES-1:0]      w_adv;
  logic [NUM_STAGES-1:0]      w_dir_d;

  always_comb begin
    w_adv    = '0;
    w_adv[0] = count_enable & ~clear & ~r_done;
    for (int k = 1; k < NUM_STAGES; k++) begin
      w_adv[k] = w_adv[k-1] & w_term[k-1];
    end
  end

  generate
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      logic [1:0]      w_mode;
      logic [SIZE-1:0] w_start;
      logic [SIZE:0]   w_lo;
      logic [SIZE:0]   w_hi;
      logic [SIZE:0]   w_st;
      logic [SIZE:0]   w_c;
      logic [SIZE:0]   w_sum;
      logic [SIZE:0]   w_diff;
      logic [SIZE:0]   w_lo_st;
      logic [SIZE:0]   w_hi_st;
      logic [SIZE-1:0] w_nxt;
      logic            w_t;
      logic            w_dn;

      assign w_mode  = mode[2*k +: 2];
      assign w_lo    = {1'b0, lo_val[k*SIZE +: SIZE]};
      assign w_hi    = {1'b0, hi_val[k*SIZE +: SIZE]};
      assign w_st    = (step_val[k*SIZE +: SIZE] == '0) ? {{SIZE{1'b0}}, 1'b1}
                                                        : {1'b0, step_val[k*SIZE +: SIZE]};
      assign w_start = (w_mode == c_MODE_DOWN) ? hi_val[k*SIZE +: SIZE] : lo_val[k*SIZE +: SIZE];
      assign w_cur[k*SIZE +: SIZE] = r_at_start ? w_start : r_count[k*SIZE +: SIZE];
      assign w_c     = {1'b0, w_cur[k*SIZE +: SIZE]};
      assign w_sum   = w_c + w_st;
      assign w_diff  = w_c - w_st;
      assign w_lo_st = w_lo + w_st;
      assign w_hi_st = w_hi - w_st;

      always_comb begin
        w_nxt = w_c[SIZE-1:0];
        w_t   = 1'b0;
        w_dn  = r_dir_down[k];
        case (w_mode)
          c_MODE_UP: begin
            if (w_c >= w_hi || w_sum > w_hi) begin
              w_nxt = w_lo[SIZE-1:0];
              w_t   = 1'b1;
            end else begin
              w_nxt = w_sum[SIZE-1:0];
            end
          end
          c_MODE_DOWN: begin
            if (w_c <= w_lo || w_c < w_lo_st) begin
              w_nxt = w_hi[SIZE-1:0];
              w_t   = 1'b1;
            end else begin
              w_nxt = w_diff[SIZE-1:0];
            end
          end
          c_MODE_BOUNCE: begin
            if (!r_dir_down[k]) begin
              if (w_c >= w_hi) begin
                w_dn  = 1'b1;
                w_nxt = (w_hi < w_lo_st) ? w_lo[SIZE-1:0] : w_hi_st[SIZE-1:0];
              end else begin
                w_nxt = (w_sum > w_hi) ? w_hi[SIZE-1:0] : w_sum[SIZE-1:0];
              end
            end else begin
              // Only the turn at the low end is terminal: one event per full sweep.
              if (w_c <= w_lo) begin
                w_dn  = 1'b0;
                w_t   = 1'b1;
                w_nxt = (w_lo_st > w_hi) ? w_hi[SIZE-1:0] : w_lo_st[SIZE-1:0];
              end else begin
                w_nxt = (w_c < w_lo_st) ? w_lo[SIZE-1:0] : w_diff[SIZE-1:0];
              end
            end
          end
          default: begin
            w_t = 1'b1;
          end
        endcase
      end

      assign w_term[k]                 = w_t;
      assign w_dir_d[k]                = w_adv[k] ? w_dn : r_dir_down[k];
      assign w_count_d[k*SIZE +: SIZE] = w_adv[k] ? w_nxt : w_cur[k*SIZE +: SIZE];
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_at_start <= 1'b1;
      r_count    <= '0;
      r_dir_down <= '0;
      r_wrap     <= '0;
      r_done     <= 1'b0;
    end else if (clear) begin
      r_at_start <= 1'b1;
      r_dir_down <= '0;
      r_wrap     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_at_start <= 1'b0;
      r_count    <= w_count_d;
      r_dir_down <= w_dir_d;
      r_wrap     <= w_adv & w_term;
      r_done     <= r_done | (oneshot & w_adv[NUM_STAGES-1] & w_term[NUM_STAGES-1]);
    end
  end

  assign count_out = w_cur;
  assign wrap_flag = r_wrap;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_flex_counter_nd.sv
// ============================================================================
// Module  : tb_flex_counter_nd
// Brief   : Scoreboard bench for flex_counter_nd with a behavioural scan model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flex_counter_nd;
  localparam int NS = 2;
  localparam int SZ = 8;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             clear;
  logic             count_enable;
  logic             oneshot;
  logic [NS*SZ-1:0] lo_val;
  logic [NS*SZ-1:0] hi_val;
  logic [NS*SZ-1:0] step_val;
  logic [NS*2-1:0]  mode;
  logic [NS*SZ-1:0] count_out;
  logic [NS-1:0]    wrap_flag;
  logic             done;

  typedef struct packed {
    logic [NS*SZ-1:0] cnt;
    logic [NS-1:0]    wrap;
    logic             done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt[NS];
  bit   m_dn[NS];
  bit   m_done;

  flex_counter_nd #(.NUM_STAGES(NS), .SIZE(SZ)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
    .oneshot(oneshot), .lo_val(lo_val), .hi_val(hi_val), .step_val(step_val),
    .mode(mode), .count_out(count_out), .wrap_flag(wrap_flag), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fld(input logic [NS*SZ-1:0] v, input int k);
    return int'(v[k*SZ +: SZ]);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NS; k++) begin
      m_cnt[k] = (mode[2*k +: 2] == 2'b01) ? fld(hi_val, k) : fld(lo_val, k);
      m_dn[k]  = 1'b0;
    end
    m_done = 1'b0;
  endfunction

  // One clock edge of the scan, computed from the bounds with plain integers.
  function automatic exp_t model_edge();
    exp_t e;
    bit   adv;
    bit   t;
    int   lo, hi, st, c;
    e.wrap = '0;
    if (clear) begin
      model_reset();
    end else begin
      adv = count_enable && !m_done;
      for (int k = 0; k < NS; k++) begin
        if (!adv) break;
        lo = fld(lo_val, k);
        hi = fld(hi_val, k);
        st = fld(step_val, k);
        if (st == 0) st = 1;
        c = m_cnt[k];
        t = 1'b0;
        case (mode[2*k +: 2])
          2'd0: if (c + st > hi) begin c = lo; t = 1'b1; end else c = c + st;
          2'd1: if (c - st < lo) begin c = hi; t = 1'b1; end else c = c - st;
          2'd2: begin
            if (!m_dn[k]) begin
              if (c >= hi) begin m_dn[k] = 1'b1; c = (hi - st > lo) ? hi - st : lo; end
              else c = (c + st < hi) ? c + st : hi;
            end else begin
              if (c <= lo) begin m_dn[k] = 1'b0; t = 1'b1; c = (lo + st < hi) ? lo + st : hi; end
              else c = (c - st > lo) ? c - st : lo;
            end
          end
          default: t = 1'b1;
        endcase
        m_cnt[k]  = c;
        e.wrap[k] = t;
        adv       = t;
      end
      if (adv && oneshot) m_done = 1'b1;
    end
    for (int k = 0; k < NS; k++) e.cnt[k*SZ +: SZ] = m_cnt[k][SZ-1:0];
    e.done = m_done;
    return e;
  endfunction

  task automatic set_stage(input int k, input int lo, input int hi, input int st, input int md);
    lo_val[k*SZ +: SZ]   = SZ'(lo);
    hi_val[k*SZ +: SZ]   = SZ'(hi);
    step_val[k*SZ +: SZ] = SZ'(st);
    mode[2*k +: 2]       = 2'(md);
  endtask

  // Drive one cycle; returns 2 time units after the edge that consumed the inputs.
  task automatic cyc(input bit en, input bit clr);
    count_enable = en;
    clear        = clr;
    q.push_back(model_edge());
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("scoreboard", 32'({count_out, wrap_flag, done}), 32'(e));
      end
    end
  end

  int seq2[5]  = '{7, 5, 3, 1, 9};
  int wrp2[5]  = '{0, 0, 0, 0, 1};
  int seq3[6]  = '{5, 6, 3, 2, 5, 6};
  int wrp3[6]  = '{0, 0, 0, 0, 1, 0};

  initial begin
    n_rst = 1'b0; clear = 1'b0; count_enable = 1'b0; oneshot = 1'b1;
    lo_val = '0; hi_val = '0; step_val = '0; mode = '0;
    set_stage(0, 0, 3, 1, 0);
    set_stage(1, 0, 2, 1, 0);
    #1;
    check("reset_state", 32'({count_out, wrap_flag, done}), 32'(0));
    model_reset();
    #11 n_rst = 1'b1;
    @(posedge clk);
    #2;

    // Raster scan with one-shot
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 1'b0);
      check("raster", 32'({count_out, wrap_flag, done}),
            32'({8'(i / 4 % 3), 8'(i % 4), (i == 12), (i % 4 == 0), (i == 12)}));
    end
    cyc(1'b1, 1'b0);
    check("oneshot_hold", 32'({count_out, wrap_flag, done}), 32'(1));

    // Down-wrap
    oneshot = 1'b0;
    set_stage(0, 1, 9, 2, 1);
    set_stage(1, 0, 3, 1, 0);
    cyc(1'b0, 1'b1);
    check("down_start", 32'(count_out[7:0]), 32'(9));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      check("down_seq", 32'({count_out[7:0], wrap_flag[0]}), 32'({8'(seq2[i]), 1'(wrp2[i])}));
    end

    // Bounce
    set_stage(0, 2, 6, 3, 2);
    cyc(1'b0, 1'b1);
    check("bounce_start", 32'(count_out[7:0]), 32'(2));
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0);
      check("bounce_seq", 32'({count_out[7:0], wrap_flag[0]}), 32'({8'(seq3[i]), 1'(wrp3[i])}));
    end

    // Hold passes carry straight through
    set_stage(0, 0, 3, 1, 3);
    set_stage(1, 0, 1, 1, 0);
    cyc(1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0);
      check("hold_carry", 32'({count_out, wrap_flag}),
            32'({8'(i % 2), 8'd0, (i % 2 == 0), 1'b1}));
    end

    // Clear beats enable
    oneshot = 1'b1;
    set_stage(0, 0, 3, 1, 0);
    set_stage(1, 0, 2, 1, 0);
    cyc(1'b0, 1'b1);
    repeat (6) cyc(1'b1, 1'b0);
    check("pre_clear", 32'(count_out), 32'(16'h0102));
    cyc(1'b1, 1'b1);
    check("clear_prio", 32'({count_out, wrap_flag, done}), 32'(0));

    // Asynchronous reset with done set
    repeat (12) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("done_before_rst", 32'(done), 32'(1));
    #3 n_rst = 1'b0;
    #1;
    check("async_reset", 32'({count_out, wrap_flag, done}), 32'(0));
    model_reset();
    #2 n_rst = 1'b1;
    @(posedge clk);
    #2;
    cyc(1'b1, 1'b0);
    check("after_reset", 32'({count_out, done}), 32'({16'h0001, 1'b0}));

    // Randomised configurations against the model
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < NS; k++) begin
        int lo, hi;
        lo = $urandom_range(0, 200);
        hi = lo + $urandom_range(0, 55);
        if ($urandom % 4 == 0) hi = 255;
        set_stage(k, lo, hi, $urandom_range(0, 9), $urandom_range(0, 3));
      end
      oneshot = 1'($urandom % 2);
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 150; i++) begin
        cyc(1'($urandom % 4 != 0), 1'($urandom % 40 == 0));
      end
    end

    count_enable = 1'b0;
    clear        = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
